// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin, LSB first, one bit per clock behind a start/done handshake.
// Define SERIAL_SUB_OVF_EN to register signed overflow; otherwise ovf is tied to 0.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             d;
    logic             bo;
    logic             accept;
    logic             last_bit;

    full_subtractor u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (d),
        .bo (bo)
    );

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    // Only WIDTH-1 bits are stored; the current bit completes the word on the last edge.
    assign res_next = {d, res_sr};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next[WIDTH-1:1];
            borrow <= bo;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                diff <= res_next;
                bout <= bo;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand sign bits are shifted out of the registers, so keep copies for the overflow test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if ((state == SHIFT) && last_bit) begin
            ovf <= (a_msb != b_msb) && (d != a_msb);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and swept checks of serial_subtractor at WIDTH=4, including mid-op start and reset abort.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             bin   = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Waits for the block to be idle, then presents one operation for a single accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tbin);
        int n = 0;
        while ((busy || done) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) checkOutput("idle_timeout", 32'd1, 32'd0);
        a     = ta;
        b     = tb;
        bin   = tbin;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int cycles, output int busy_cycles);
        bit found = 1'b0;
        cycles      = 0;
        busy_cycles = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                cycles = k - 1;
                found  = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
        end
        if (!found) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH-1:0] exp_diff, input logic exp_bout,
                               input logic exp_ovf);
        checkOutput({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        checkOutput({tag, "_bout"}, 32'(bout), 32'(exp_bout));
        checkOutput({tag, "_ovf"}, 32'(ovf), 32'(OVF_ON ? exp_ovf : 1'b0));
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tbin, input logic [WIDTH-1:0] exp_diff, input logic exp_bout,
                         input logic exp_ovf);
        int cyc;
        int bc;
        applyStimulus(ta, tb, tbin);
        waitDone(cyc, bc);
        checkResult(tag, exp_diff, exp_bout, exp_ovf);
    endtask

    initial begin
        int cyc;
        int bc;
        int extra;
        int gap;
        bit found;
        int ed;
        logic [WIDTH-1:0] exp_d;

        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkResult("reset", 4'b0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 9 - 10: latency, busy width, single-cycle done and hold afterwards
        applyStimulus(4'b1001, 4'b1010, 1'b0);
        waitDone(cyc, bc);
        checkOutput("op1_latency", 32'(cyc), 32'd4);
        checkOutput("op1_busy_cycles", 32'(bc), 32'd4);
        checkOutput("op1_busy_at_done", 32'(busy), 32'd0);
        checkResult("op1", 4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("op1_done_one_cycle", 32'(done), 32'd0);
        checkResult("op1_hold", 4'b1111, 1'b1, 1'b0);

        applyStimulus(4'b1100, 4'b0011, 1'b0);
        @(negedge clk);
        checkOutput("op2_midop_diff_held", 32'(diff), 32'hF);
        waitDone(cyc, bc);
        checkResult("op2", 4'b1001, 1'b0, 1'b0);

        runOp("zero_minus_bin", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);
        runOp("a_eq_b", 4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0);
        runOp("max_minus_zero", 4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0);
        runOp("ovf_none", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

        // start re-asserted with different operands during SHIFT must be ignored
        applyStimulus(4'b0110, 4'b0010, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a     = 4'b1111;
        b     = 4'b0000;
        bin   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc, bc);
        checkResult("restart_ignored", 4'b0100, 1'b0, 1'b0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        checkOutput("restart_extra_done", 32'(extra), 32'd0);

        runOp("ovf_set", 4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1);

        // abort after two SHIFT edges
        applyStimulus(4'b1001, 4'b0011, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkResult("abort", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("post_reset", 4'b0101, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);

        // sweep with start held high; operands change only at each done pulse
        a     = 4'($urandom_range(0, 15));
        b     = 4'($urandom_range(0, 15));
        bin   = 1'($urandom_range(0, 1));
        start = 1'b1;
        for (int op = 0; op < 1000; op++) begin
            found = 1'b0;
            gap   = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                gap = k;
                if (done) begin
                    found = 1'b1;
                    break;
                end
            end
            if (!found) begin
                checkOutput("sweep_timeout", 32'd0, 32'd1);
                break;
            end
            ed    = int'(a) - int'(b) - int'(bin);
            exp_d = 4'(ed);
            checkResult("sweep", exp_d, ed < 0, (a[3] != b[3]) && (exp_d[3] != a[3]));
            if (op > 0) checkOutput("sweep_spacing", 32'(gap), 32'd6);
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            bin = 1'($urandom_range(0, 1));
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, multi-cycle subtractor that computes A − B − Bin one bit per clock, LSB first, through a single full-subtractor stage and a borrow flip-flop.
- Inverse arithmetic direction of the team's combinational 4-bit ripple adder.
- Used where area matters more than latency; sits behind a start/done handshake in the datapath.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while idle
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result is valid
- diff  output  WIDTH  difference, A − B − Bin mod 2^WIDTH
- bout  output  1  borrow-out; 1 when A < B + Bin, unsigned
- ovf  output  1  signed overflow; see Optional Feature

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy, done, diff, bout, ovf=0.
  - Internal shift registers, bit counter and borrow FF cleared.
- States:
  - IDLE
  - SHIFT
  - DONE
- IDLE:
  - busy=0.
  - start=1 at a clock edge: capture a, b into shift registers and bin into the borrow FF; clear counter; go to SHIFT.
- SHIFT:
  - busy=1.
  - Each edge: full_subtractor(a_sr[0], b_sr[0], borrow) produces d and bo.
  - d shifts into the MSB of the result register (right shift); borrow ← bo; a_sr and b_sr shift right; counter increments.
  - On the edge that processes bit WIDTH−1: diff ← final result, bout ← bo, done ← 1, go to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE; a back-to-back operation starts from IDLE on the following cycle.
- Latency: start sampled at edge 0 → done high after edge WIDTH, i.e. WIDTH cycles later.
  - Throughput: one operation per WIDTH+2 cycles.
- diff and bout:
  - Hold their value from the last completed operation until the next completion.
  - They are not updated mid-operation.
- start while busy: ignored; no restart and no corruption of the running operation.
- Input stability: a, b, bin are sampled only at the accepting edge; they may change freely afterwards.
- Reset mid-operation: abort immediately and return to reset values; no done pulse.
- Arithmetic:
  - Full subtractor: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).
  - Result equals the combinational (a − b − bin) truncated to WIDTH bits; bout = carry-inverse of the unsigned subtraction.
- Boundary cases:
  - a=b, bin=0 → diff=0, bout=0.
  - a=0, b=0, bin=1 → diff all-ones, bout=1.
  - a=2^WIDTH−1, b=0, bin=0 → diff=a, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - ovf is registered alongside bout at completion.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), where a and b are the captured operands; bin is included in diff.
  - Held like diff.
- Undefined:
  - The ovf port still exists and is tied to 0.
  - No MSB-capture logic is synthesised.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Counter width constant $clog2(WIDTH).
- One natural sub-module: full_subtractor (d, bo, x, y, bi), purely combinational and instantiated once.
- The FSM, shift registers and counter live in serial_subtractor.

Test Plan:
- WIDTH=4; a=4'b1001, b=4'b1010, bin=0, start pulse → done 4 cycles later; diff=4'b1111, bout=1; busy high exactly 4 cycles.
- a=4'b1100, b=4'b0011, bin=0 → diff=4'b1001, bout=0. Then a=0, b=0, bin=1 → diff=4'b1111, bout=1.
- Start with a=4'b0110, b=4'b0010; drive start=1 with a=4'b1111 during SHIFT → result is diff=4'b0100 and only one done pulse.
- Assert rst_n=0 for 1 cycle after 2 SHIFT cycles → busy, done, diff, bout all 0 immediately; the next start with a=4'b0101, b=4'b0001 completes with diff=4'b0100.
- SERIAL_SUB_OVF_EN defined: a=4'b0111, b=4'b1000 → diff=4'b1111, ovf=1. a=4'b0011, b=4'b0001 → ovf=0. Macro undefined → ovf always 0.
- Random sweep, 1000 ops, with start held high continuously → every diff/bout matches the (a−b−bin) model; done-to-done spacing is exactly 6 cycles.
